// File: rtl/eth_tx_sched.sv
// Fixed-priority Ethernet transmit scheduler with start timeout and inter-frame gap.
// Define ETH_TX_SCHED_WDOG_EN to add a frame-duration watchdog in WAIT_DONE.
module eth_tx_sched #(
    parameter int unsigned IFG_CYCLES    = 12,
    parameter int unsigned START_TIMEOUT = 16,
    parameter int unsigned WDOG_CYCLES   = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arp_req,
    input  logic        arp_rx_reply,
    input  logic        icmp_rx_req,
    input  logic [15:0] icmp_byte_num,
    input  logic        udp_tx_en,
    input  logic [15:0] udp_tx_data_num,
    input  logic        tx_rdy,
    output logic        eth_tx_start,
    output logic [1:0]  eth_tx_type,
    output logic        arp_tx_type,
    output logic [15:0] iudp_tx_byte_num,
    output logic        udp_busy,
    output logic        err_timeout
);

    // One shared counter, sized for the largest limit it may have to reach.
    localparam int unsigned MaxAB  = (IFG_CYCLES > START_TIMEOUT) ? IFG_CYCLES : START_TIMEOUT;
    localparam int unsigned CntMax = (MaxAB > WDOG_CYCLES) ? MaxAB : WDOG_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [1:0] TypeArp  = 2'd1;
    localparam logic [1:0] TypeIcmp = 2'd2;
    localparam logic [1:0] TypeUdp  = 2'd3;

    typedef enum logic [2:0] {StIdle, StStart, StWaitBusy, StWaitDone, StGap} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            arp_rep_p_q, arp_req_p_q, icmp_p_q, udp_p_q;
    logic            arp_rep_p_d, arp_req_p_d, icmp_p_d, udp_p_d;
    logic [15:0]     icmp_len_q, udp_len_q;
    logic [1:0]      type_q, type_d;
    logic            arp_type_q, arp_type_d;
    logic [15:0]     byte_num_q, byte_num_d;
    logic            grant, err;
    logic [1:0]      grant_type;
    logic [15:0]     grant_len;
    logic            any_p;

    assign any_p   = arp_rep_p_q | arp_req_p_q | icmp_p_q | udp_p_q;
    assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);

    always_comb begin
        grant_type = TypeUdp;
        grant_len  = udp_len_q;
        if (arp_rep_p_q || arp_req_p_q) begin
            grant_type = TypeArp;
            grant_len  = '0;
        end else if (icmp_p_q) begin
            grant_type = TypeIcmp;
            grant_len  = icmp_len_q;
        end
    end

    // A pulse in the grant cycle of its own source keeps the flag set.
    assign arp_rep_p_d = arp_rx_reply | (arp_rep_p_q & ~grant);
    assign arp_req_p_d = arp_req | (arp_req_p_q & ~(grant & ~arp_rep_p_q));
    assign icmp_p_d    = icmp_rx_req | (icmp_p_q & ~(grant & (grant_type == TypeIcmp)));
    assign udp_p_d     = udp_tx_en | (udp_p_q & ~(grant & (grant_type == TypeUdp)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        type_d     = type_q;
        arp_type_d = arp_type_q;
        byte_num_d = byte_num_q;
        grant      = 1'b0;
        err        = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (any_p && tx_rdy) begin
                    grant      = 1'b1;
                    state_d    = StStart;
                    type_d     = grant_type;
                    arp_type_d = arp_rep_p_q;
                    byte_num_d = grant_len;
                end
            end
            StStart: begin
                state_d = StWaitBusy;
                cnt_d   = CntW'(1);
            end
            StWaitBusy: begin
                if (!tx_rdy) begin
                    state_d = StWaitDone;
                    cnt_d   = CntW'(1);
                end else if (cnt_q >= CntW'(START_TIMEOUT)) begin
                    err        = 1'b1;
                    state_d    = StGap;
                    cnt_d      = CntW'(1);
                    type_d     = '0;
                    arp_type_d = 1'b0;
                    byte_num_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StWaitDone: begin
                if (tx_rdy) begin
                    state_d = StGap;
                    cnt_d   = CntW'(1);
                end else begin
`ifdef ETH_TX_SCHED_WDOG_EN
                    if (cnt_q >= CntW'(WDOG_CYCLES)) begin
                        err     = 1'b1;
                        state_d = StGap;
                        cnt_d   = CntW'(1);
                    end else begin
                        cnt_d = cnt_inc;
                    end
`else
                    cnt_d = cnt_q;
`endif
                end
            end
            StGap: begin
                if (cnt_q >= CntW'(IFG_CYCLES)) begin
                    state_d    = StIdle;
                    cnt_d      = '0;
                    type_d     = '0;
                    arp_type_d = 1'b0;
                    byte_num_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            arp_rep_p_q <= 1'b0;
            arp_req_p_q <= 1'b0;
            icmp_p_q    <= 1'b0;
            udp_p_q     <= 1'b0;
            icmp_len_q  <= '0;
            udp_len_q   <= '0;
            type_q      <= '0;
            arp_type_q  <= 1'b0;
            byte_num_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            arp_rep_p_q <= arp_rep_p_d;
            arp_req_p_q <= arp_req_p_d;
            icmp_p_q    <= icmp_p_d;
            udp_p_q     <= udp_p_d;
            if (icmp_rx_req) icmp_len_q <= icmp_byte_num;
            if (udp_tx_en)   udp_len_q  <= udp_tx_data_num;
            type_q      <= type_d;
            arp_type_q  <= arp_type_d;
            byte_num_q  <= byte_num_d;
        end
    end

    assign eth_tx_start     = (state_q == StStart);
    assign eth_tx_type      = type_q;
    assign arp_tx_type      = arp_type_q;
    assign iudp_tx_byte_num = byte_num_q;
    assign udp_busy         = udp_p_q | ((type_q == TypeUdp) && (state_q != StIdle));
    assign err_timeout      = err;

endmodule
